// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART command-link frame parser.
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        CMD,
        LEN_H,
        LEN_L,
        PAYLOAD,
        CHK
    } state_t;

    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/frame_chk_acc.sv
// 8-bit frame checksum accumulator: wrapping sum, or XOR when CHK_XOR != 0.
module frame_chk_acc #(
    parameter int CHK_XOR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= (CHK_XOR != 0) ? (acc ^ din) : (acc + din);
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: HDR0 HDR1 CMD LEN_H LEN_L PAYLOAD[LEN] CHK, payload streamed as it arrives.
// Optional inter-byte timeout enabled by defining UART_FRAME_PARSER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | hunting for HDR0
// SYNC    | HDR0 seen, expecting HDR1 (HDR0 again resyncs)
// CMD     | expecting command byte
// LEN_H   | expecting length high byte
// LEN_L   | expecting length low byte, length checked here
// PAYLOAD | streaming LEN payload bytes
// CHK     | expecting checksum byte
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [7:0] HDR0            = 8'hAA,
    parameter logic [7:0] HDR1            = 8'h55,
    parameter int         MAX_PAYLOAD_LEN = 256,
    parameter int         CHK_XOR         = 0,
    parameter int         TIMEOUT_CYCLES  = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [7:0]  cmd_out,
    output logic [15:0] len_out,
    output logic        hdr_valid,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic [15:0] payload_idx,
    output logic        payload_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_LEN);

    state_t      state;
    logic [7:0]  len_h;
    logic [15:0] cnt;
    logic [15:0] len_rx;
    logic [7:0]  acc;
    logic        acc_clr;
    logic        acc_add;
    logic        tmo_hit;

    assign len_rx  = {len_h, in_data};
    assign acc_clr = in_valid && (state == SYNC) && (in_data == HDR1);
    assign acc_add = in_valid && ((state == CMD) || (state == LEN_H) ||
                                  (state == LEN_L) || (state == PAYLOAD));

    frame_chk_acc #(
        .CHK_XOR(CHK_XOR)
    ) u_chk_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .add_en(acc_add),
        .din   (in_data),
        .acc   (acc)
    );

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;

    // Down-counter reloaded by every byte; expiry on the TIMEOUT_CYCLES-th silent cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= TMO_LOAD;
        end else if (in_valid || (state == IDLE) || tmo_hit) begin
            tmo_cnt <= TMO_LOAD;
        end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    assign tmo_hit = !in_valid && (state != IDLE) && (tmo_cnt == TW'(1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            len_h         <= '0;
            cnt           <= '0;
            cmd_out       <= '0;
            len_out       <= '0;
            hdr_valid     <= 1'b0;
            payload_valid <= 1'b0;
            payload_data  <= '0;
            payload_idx   <= '0;
            payload_last  <= 1'b0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= '0;
            busy          <= 1'b0;
        end else begin
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            if (tmo_hit) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                hdr_valid <= 1'b0;
            end else if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (in_data == HDR0) begin
                            state <= SYNC;
                            busy  <= 1'b1;
                        end
                    end
                    SYNC: begin
                        if (in_data == HDR1) begin
                            state     <= CMD;
                            hdr_valid <= 1'b0;
                        end else if (in_data != HDR0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    CMD: begin
                        cmd_out <= in_data;
                        state   <= LEN_H;
                    end
                    LEN_H: begin
                        len_h <= in_data;
                        state <= LEN_L;
                    end
                    LEN_L: begin
                        if (len_rx > MAX_LEN) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            hdr_valid <= 1'b0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            len_out   <= len_rx;
                            hdr_valid <= 1'b1;
                            cnt       <= '0;
                            state     <= (len_rx == 16'd0) ? CHK : PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        payload_valid <= 1'b1;
                        payload_data  <= in_data;
                        payload_idx   <= cnt;
                        payload_last  <= (cnt == len_out - 16'd1);
                        if (cnt == len_out - 16'd1) begin
                            state <= CHK;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    CHK: begin
                        if (in_data == acc) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                            hdr_valid <= 1'b0;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: sum-mode DUT checked via event queue, XOR-mode DUT checked directly.
module tb_uart_frame_parser;

    localparam int K_PAY = 0;
    localparam int K_OK  = 1;
    localparam int K_ERR = 2;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic [15:0] idx;
        logic        last;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [7:0]  cmd_out;
    logic [15:0] len_out;
    logic        hdr_valid;
    logic        payload_valid;
    logic [7:0]  payload_data;
    logic [15:0] payload_idx;
    logic        payload_last;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    logic        xin_valid = 1'b0;
    logic [7:0]  xin_data = '0;
    logic [7:0]  x_cmd_out;
    logic [15:0] x_len_out;
    logic        x_hdr_valid;
    logic        x_payload_valid;
    logic [7:0]  x_payload_data;
    logic [15:0] x_payload_idx;
    logic        x_payload_last;
    logic        x_frame_ok;
    logic        x_frame_err;
    logic [1:0]  x_err_code;
    logic        x_busy;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_PAYLOAD_LEN(256),
        .CHK_XOR        (0),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .cmd_out      (cmd_out),
        .len_out      (len_out),
        .hdr_valid    (hdr_valid),
        .payload_valid(payload_valid),
        .payload_data (payload_data),
        .payload_idx  (payload_idx),
        .payload_last (payload_last),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    uart_frame_parser #(
        .MAX_PAYLOAD_LEN(256),
        .CHK_XOR        (1),
        .TIMEOUT_CYCLES (100)
    ) dut_xor (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (xin_valid),
        .in_data      (xin_data),
        .cmd_out      (x_cmd_out),
        .len_out      (x_len_out),
        .hdr_valid    (x_hdr_valid),
        .payload_valid(x_payload_valid),
        .payload_data (x_payload_data),
        .payload_idx  (x_payload_idx),
        .payload_last (x_payload_last),
        .frame_ok     (x_frame_ok),
        .frame_err    (x_frame_err),
        .err_code     (x_err_code),
        .busy         (x_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input logic [15:0] idx,
                        input logic last, input logic [1:0] code);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.idx  = idx;
        e.last = last;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected no event at %0t", k, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == K_PAY && e.kind == K_PAY) begin
                chk("payload_data", payload_data, e.data);
                chk("payload_idx", payload_idx, e.idx);
                chk("payload_last", payload_last, e.last);
            end
            if (k == K_ERR && e.kind == K_ERR) chk("err_code", err_code, e.code);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_ok && frame_err) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ok_err_overlap: got both frame_ok and frame_err, expected at most one");
            end
            if (payload_valid) pop_cmp(K_PAY);
            if (frame_ok) pop_cmp(K_OK);
            if (frame_err) pop_cmp(K_ERR);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xsend(input logic [7:0] b);
        xin_valid = 1'b1;
        xin_data  = b;
        @(posedge clk);
        #1;
        xin_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input bq_t pl, input logic [7:0] ck,
                             input bit good, input int gap);
        logic [15:0] len;
        len = 16'(pl.size());
        for (int i = 0; i < pl.size(); i++) push(K_PAY, pl[i], 16'(i), (i == pl.size() - 1), 2'd0);
        push(good ? K_OK : K_ERR, 8'h00, 16'h0, 1'b0, 2'd1);
        send(8'hAA, gap);
        send(8'h55, gap);
        send(cmd, gap);
        send(len[15:8], gap);
        send(len[7:0], gap);
        chk("hdr_valid", hdr_valid, 1);
        chk("cmd_out", cmd_out, cmd);
        chk("len_out", len_out, len);
        for (int i = 0; i < pl.size(); i++) send(pl[i], gap);
        send(ck, gap);
    endtask

    task automatic xframe(input bq_t bs, input bit good);
        for (int i = 0; i < bs.size(); i++) xsend(bs[i]);
        chk("x_frame_ok", x_frame_ok, good);
        chk("x_frame_err", x_frame_err, !good);
        if (!good) chk("x_err_code", x_err_code, 2'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t pl;
        bq_t xb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_outs", {frame_ok, frame_err, payload_valid, payload_last}, 0);
        chk("rst_cmd_len", {cmd_out, len_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pl.delete();
        run_frame(8'hFF, pl, 8'hFF, 1, 0);
        send(8'h00, 1);
        chk("err_code_zero", err_code, 0);

        pl.delete();
        pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
        run_frame(8'h01, pl, 8'h3D, 1, 0);
        run_frame(8'h01, pl, 8'h3C, 0, 0);
        send(8'h00, 1);
        chk("hdr_cleared_on_err", hdr_valid, 0);
        run_frame(8'h01, pl, 8'h3D, 1, 2);

        pl.delete();
        pl.push_back(8'h5A);
        run_frame(8'h07, pl, 8'h62, 1, 0);
        send(8'h00, 1);
        chk("err_code_held", err_code, 1);

        push(K_ERR, 8'h00, 16'h0, 1'b0, 2'd2);
        send(8'hAA, 0); send(8'h55, 0); send(8'h02, 0); send(8'h01, 0); send(8'h01, 0);
        send(8'h04, 1);
        chk("len_err_busy", busy, 0);
        chk("len_err_hdr", hdr_valid, 0);
        chk("len_err_code", err_code, 2);

        send(8'hAA, 0);
        pl.delete();
        run_frame(8'hFF, pl, 8'hFF, 1, 0);

        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        run_frame(8'h03, pl, 8'h84, 1, 0);

        send(8'hAA, 0); send(8'h55, 0); send(8'h01, 0);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #3;
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pl.delete();
        run_frame(8'hFF, pl, 8'hFF, 1, 0);

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        push(K_ERR, 8'h00, 16'h0, 1'b0, 2'd3);
        send(8'hAA, 0); send(8'h55, 0); send(8'h01, 0);
        repeat (99) begin
            @(posedge clk);
            #1;
        end
        chk("tmo_not_yet", busy, 1);
        @(posedge clk);
        #1;
        chk("tmo_busy", busy, 0);
        chk("tmo_code", err_code, 3);

        push(K_OK, 8'h00, 16'h0, 1'b0, 2'd0);
        send(8'hAA, 0); send(8'h55, 0); send(8'h01, 0);
        repeat (99) begin
            @(posedge clk);
            #1;
        end
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
`endif

        xb.delete();
        xb.push_back(8'hAA); xb.push_back(8'h55); xb.push_back(8'hFF);
        xb.push_back(8'h00); xb.push_back(8'h00); xb.push_back(8'hFF);
        xframe(xb, 1);
        xb[5] = 8'h00;
        xframe(xb, 0);
        xb.delete();
        xb.push_back(8'hAA); xb.push_back(8'h55); xb.push_back(8'h01);
        xb.push_back(8'h00); xb.push_back(8'h04);
        xb.push_back(8'hDE); xb.push_back(8'hAD); xb.push_back(8'hBE); xb.push_back(8'hEF);
        xb.push_back(8'h27);
        xframe(xb, 1);
        xb[9] = 8'h3D;
        xframe(xb, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
